// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared types, line table and cell helpers for the tic-tac-toe CPU player
package tictactoe_pkg;

  typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} cell_e;

  typedef enum logic [2:0] {IDLE, THINK, CHOOSE, STEP_HI, STEP_LO, PLACE, DONE} state_e;

  // Entry = three {row,col} nibbles, first cell of the line in the low nibble.
  localparam logic [7:0][2:0][3:0] LINE_CELLS = {
    12'hDA7, 12'hFA5, 12'hFB7, 12'hEA6, 12'hD95, 12'hFED, 12'hBA9, 12'h765
  };

  // Row-major cell indices, entry 0 tried first: centre, corners, edges.
  localparam logic [8:0][3:0] FALLBACK_ORDER = {
    4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4
  };

  function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] r;
    logic [3:0] c;
    r = {2'b00, row} - 4'd1;
    c = {2'b00, col} - 4'd1;
    return (r * 4'd3) + c;
  endfunction

  function automatic logic [3:0] cell_rc(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'b0101;
      4'd1:    return 4'b0110;
      4'd2:    return 4'b0111;
      4'd3:    return 4'b1001;
      4'd4:    return 4'b1010;
      4'd5:    return 4'b1011;
      4'd6:    return 4'b1101;
      4'd7:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/tictactoe_cpu_player_if.sv
// rtl/tictactoe_cpu_player_if.sv - game-side signal bundle between the board logic and the CPU player
interface tictactoe_cpu_player_if;

  logic       turn;
  logic [1:0] cpu_mark;
  logic [1:0] board [3:1][3:1];
  logic       move;
  logic       select;
  logic       busy;
  logic [1:0] target_row;
  logic [1:0] target_col;
  logic       no_move;

  modport master (
    output turn, cpu_mark, board,
    input  move, select, busy, target_row, target_col, no_move
  );

  modport slave (
    input  turn, cpu_mark, board,
    output move, select, busy, target_row, target_col, no_move
  );

endinterface

// File: rtl/tictactoe_line_eval.sv
// rtl/tictactoe_line_eval.sv - counts CPU, opponent and empty cells on one three-cell line
module tictactoe_line_eval
  import tictactoe_pkg::*;
(
  input  logic [1:0] cell0_i,
  input  logic [1:0] cell1_i,
  input  logic [1:0] cell2_i,
  input  logic [1:0] cpu_mark_i,
  output logic [1:0] n_cpu_o,
  output logic [1:0] n_opp_o,
  output logic [1:0] n_empty_o,
  output logic [1:0] empty_pos_o
);

  logic [2:0][1:0] cells;
  logic            mark_valid;

  assign cells      = {cell2_i, cell1_i, cell0_i};
  assign mark_valid = (cpu_mark_i == P1) || (cpu_mark_i == P2);

  // Descending scan so empty_pos_o ends on the lowest empty position.
  always_comb begin
    n_cpu_o     = '0;
    n_opp_o     = '0;
    n_empty_o   = '0;
    empty_pos_o = '0;
    for (int i = 2; i >= 0; i--) begin
      if (cells[i] == EMPTY) begin
        n_empty_o   = n_empty_o + 2'd1;
        empty_pos_o = 2'(i);
      end else if (mark_valid && (cells[i] == cpu_mark_i)) begin
        n_cpu_o = n_cpu_o + 2'd1;
      end else begin
        n_opp_o = n_opp_o + 2'd1;
      end
    end
  end

endmodule

// File: rtl/tictactoe_cpu_player.sv
// rtl/tictactoe_cpu_player.sv - CPU opponent: scans a board snapshot, picks win/block/fallback, steps the cursor and places
module tictactoe_cpu_player
  import tictactoe_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  tictactoe_cpu_player_if.slave        bus
);

  state_e          state_q, state_d;
  logic [8:0][1:0] snap_q, snap_d;
  logic [1:0]      mark_q, mark_d;
  logic [2:0]      line_q, line_d;
  logic            win_q, win_d, blk_q, blk_d;
  logic [3:0]      win_cell_q, win_cell_d, blk_cell_q, blk_cell_d;
  logic [3:0]      k_q, k_d;
  logic [1:0]      row_q, row_d, col_q, col_d;

  logic [1:0]      n_cpu, n_opp, n_empty, empty_pos;
  logic [2:0][3:0] line_rc;
  logic [2:0][1:0] line_cells;
  logic [3:0]      empty_cell;
  logic            any_empty;
  logic [3:0]      fb_cell, pick_cell, pick_rc;
  logic            active;

  assign line_rc    = LINE_CELLS[line_q];
  assign empty_cell = cell_idx(line_rc[empty_pos][3:2], line_rc[empty_pos][1:0]);
  assign active     = (state_q == THINK) || (state_q == CHOOSE) || (state_q == STEP_HI) ||
                      (state_q == STEP_LO) || (state_q == PLACE);

  always_comb begin
    line_cells = '0;
    for (int p = 0; p < 3; p++) begin
      line_cells[p] = snap_q[cell_idx(line_rc[p][3:2], line_rc[p][1:0])];
    end
  end

  tictactoe_line_eval u_line_eval (
    .cell0_i    (line_cells[0]),
    .cell1_i    (line_cells[1]),
    .cell2_i    (line_cells[2]),
    .cpu_mark_i (mark_q),
    .n_cpu_o    (n_cpu),
    .n_opp_o    (n_opp),
    .n_empty_o  (n_empty),
    .empty_pos_o(empty_pos)
  );

  always_comb begin
    any_empty = 1'b0;
    fb_cell   = '0;
    for (int i = 8; i >= 0; i--) begin
      if (snap_q[FALLBACK_ORDER[i]] == EMPTY) begin
        any_empty = 1'b1;
        fb_cell   = FALLBACK_ORDER[i];
      end
    end
    if (win_q)      pick_cell = win_cell_q;
    else if (blk_q) pick_cell = blk_cell_q;
    else            pick_cell = fb_cell;
    pick_rc = cell_rc(pick_cell);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      mark_q     <= '0;
      line_q     <= '0;
      win_q      <= 1'b0;
      blk_q      <= 1'b0;
      win_cell_q <= '0;
      blk_cell_q <= '0;
      k_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      mark_q     <= mark_d;
      line_q     <= line_d;
      win_q      <= win_d;
      blk_q      <= blk_d;
      win_cell_q <= win_cell_d;
      blk_cell_q <= blk_cell_d;
      k_q        <= k_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    mark_d     = mark_q;
    line_d     = line_q;
    win_d      = win_q;
    blk_d      = blk_q;
    win_cell_d = win_cell_q;
    blk_cell_d = blk_cell_q;
    k_d        = k_q;
    row_d      = row_q;
    col_d      = col_q;
    case (state_q)
      IDLE: if (bus.turn) begin
        state_d = THINK;
        for (int r = 1; r <= 3; r++) begin
          for (int c = 1; c <= 3; c++) begin
            snap_d[cell_idx(2'(r), 2'(c))] = bus.board[r][c];
          end
        end
        mark_d = bus.cpu_mark;
        line_d = '0;
        win_d  = 1'b0;
        blk_d  = 1'b0;
        k_d    = '0;
        row_d  = '0;
        col_d  = '0;
      end
      THINK: begin
        if ((n_cpu == 2'd2) && (n_empty == 2'd1) && !win_q) begin
          win_d      = 1'b1;
          win_cell_d = empty_cell;
        end
        if ((n_opp == 2'd2) && (n_empty == 2'd1) && !blk_q) begin
          blk_d      = 1'b1;
          blk_cell_d = empty_cell;
        end
        line_d = line_q + 3'd1;
        if (line_q == 3'd7) state_d = CHOOSE;
      end
      CHOOSE: begin
        if (!any_empty) begin
          state_d = DONE;
        end else begin
          row_d   = pick_rc[3:2];
          col_d   = pick_rc[1:0];
          k_d     = pick_cell;
          state_d = (pick_cell == 4'd0) ? PLACE : STEP_HI;
        end
      end
      STEP_HI: state_d = STEP_LO;
      STEP_LO: begin
        k_d     = k_q - 4'd1;
        state_d = (k_q == 4'd1) ? PLACE : STEP_HI;
      end
      PLACE:   state_d = DONE;
      DONE:    if (!bus.turn) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A withdrawn turn abandons the move in progress.
    if (active && !bus.turn) begin
      state_d = IDLE;
      k_d     = '0;
      row_d   = '0;
      col_d   = '0;
    end
  end

  always_comb begin
    bus.move       = (state_q == STEP_HI);
    bus.select     = (state_q == PLACE);
    bus.busy       = active;
    bus.no_move    = (state_q == CHOOSE) && !any_empty;
    bus.target_row = row_q;
    bus.target_col = col_q;
  end

endmodule

// File: tb/tb_tictactoe_cpu_player.sv
// tb/tb_tictactoe_cpu_player.sv - directed self-checking bench for the tic-tac-toe CPU player
module tb_tictactoe_cpu_player;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  tictactoe_cpu_player_if bif ();

  tictactoe_cpu_player dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++)
        bif.board[r][c] = 2'b00;
  endtask

  task automatic end_turn();
    bif.turn = 1'b0;
    tick();
    tick();
  endtask

  // Drives one full turn; latency is counted in edges, the sampling edge being 1.
  task automatic run_turn(input string tag, input int er, input int ec, input int ek);
    int moves, sel_at, both, busy_gap, extra;
    moves = 0; sel_at = -1; both = 0; busy_gap = 0; extra = 0;
    bif.turn = 1'b1;
    for (int n = 1; n <= 40 && sel_at < 0; n++) begin
      tick();
      if (bif.move) moves++;
      if (bif.move && bif.select) both++;
      if (!bif.busy) busy_gap++;
      if (bif.select) sel_at = n;
    end
    check({tag, " moves"}, moves, ek);
    check({tag, " latency"}, sel_at, 10 + 2 * ek);
    check({tag, " move_and_select"}, both, 0);
    check({tag, " busy_gap"}, busy_gap, 0);
    check({tag, " row"}, int'(bif.target_row), er);
    check({tag, " col"}, int'(bif.target_col), ec);
    tick();
    check({tag, " busy_done"}, int'(bif.busy), 0);
    repeat (6) begin
      tick();
      if (bif.select || bif.move) extra++;
    end
    check({tag, " held_turn_replay"}, extra, 0);
    check({tag, " row_held"}, int'(bif.target_row), er);
    check({tag, " col_held"}, int'(bif.target_col), ec);
    end_turn();
  endtask

  initial begin
    int moves, sels, nomv;
    n_checks = 0;
    n_fail   = 0;
    rst          = 1'b1;
    bif.turn     = 1'b0;
    bif.cpu_mark = 2'b01;
    clear_board();
    #2;
    check("rst move", int'(bif.move), 0);
    check("rst select", int'(bif.select), 0);
    check("rst busy", int'(bif.busy), 0);
    check("rst no_move", int'(bif.no_move), 0);
    check("rst row", int'(bif.target_row), 0);
    check("rst col", int'(bif.target_col), 0);
    tick();
    tick();
    rst = 1'b0;

    run_turn("empty", 2, 2, 4);

    bif.board[1][1] = 2'b01; bif.board[1][2] = 2'b01;
    bif.board[2][1] = 2'b10; bif.board[2][2] = 2'b10;
    run_turn("win_over_block", 1, 3, 2);

    bif.cpu_mark = 2'b10;
    run_turn("win_p2", 2, 3, 5);

    clear_board();
    bif.cpu_mark = 2'b01;
    bif.board[1][1] = 2'b01;
    bif.board[3][1] = 2'b10; bif.board[3][2] = 2'b10;
    run_turn("block", 3, 3, 8);

    clear_board();
    bif.board[1][1] = 2'b01; bif.board[1][2] = 2'b10;
    run_turn("mark01_fallback", 2, 2, 4);
    bif.cpu_mark = 2'b11;
    run_turn("mark11_all_opp", 1, 3, 2);

    bif.cpu_mark = 2'b01;
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++)
        bif.board[r][c] = ((r + c) % 2 == 0) ? 2'b01 : 2'b10;
    moves = 0; sels = 0; nomv = 0;
    bif.turn = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bif.move) moves++;
      if (bif.select) sels++;
      if (bif.no_move) nomv++;
      if (n == 9) check("full no_move_at_choose", int'(bif.no_move), 1);
      if (n == 10) begin
        check("full busy_after_choose", int'(bif.busy), 0);
        check("full row", int'(bif.target_row), 0);
        check("full col", int'(bif.target_col), 0);
      end
    end
    check("full moves", moves, 0);
    check("full selects", sels, 0);
    check("full no_move_pulses", nomv, 1);
    end_turn();

    clear_board();
    moves = 0; sels = 0;
    bif.turn = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (bif.move) moves++;
    end
    check("abort third_step_hi", int'(bif.move), 1);
    check("abort moves_before", moves, 3);
    bif.turn = 1'b0;
    tick();
    check("abort move", int'(bif.move), 0);
    check("abort busy", int'(bif.busy), 0);
    check("abort row", int'(bif.target_row), 0);
    check("abort col", int'(bif.target_col), 0);
    repeat (20) begin
      tick();
      if (bif.select) sels++;
    end
    check("abort selects", sels, 0);

    bif.board[1][1] = 2'b01; bif.board[1][2] = 2'b01;
    bif.board[2][1] = 2'b10; bif.board[2][2] = 2'b10;
    bif.turn = 1'b1;
    repeat (14) tick();
    check("rst_place select_before", int'(bif.select), 1);
    rst = 1'b1;
    #1;
    check("rst_place select", int'(bif.select), 0);
    check("rst_place busy", int'(bif.busy), 0);
    check("rst_place row", int'(bif.target_row), 0);
    tick();
    rst = 1'b0;
    run_turn("after_rst", 1, 3, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
